// File: rtl/word_packer_pkg.sv
// Shared constants, accumulator state encoding and the count-width helper
// used by the word packer and its slot accumulator.
package word_packer_pkg;

    localparam logic MODE_PACK = 1'b0;
    localparam logic MODE_REPL = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } acc_state_e;

    // Ceiling log2; clog2(RATIO+1) gives a count wide enough to hold RATIO.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/packer_accum.sv
// Slot accumulator: holds partially packed words, decodes per-slot write
// enables, and presents the completed word/count on the completing beat.
module packer_accum
    import word_packer_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1,
    localparam int CW       = clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_en,
    input  logic                  mode,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_last,
    output logic                  done,
    output logic [RATIO*IN_W-1:0] word,
    output logic [CW-1:0]         cnt
);

    acc_state_e                   state_q, state_d;
    logic [CW-1:0]                count_q, count_d, count_inc;
    logic [RATIO-1:0][IN_W-1:0]   slots_q, slots_d, slots_wr;
    logic [RATIO-1:0]             we;
    logic                         mode_q, mode_d, eff_mode;

    // Mode is latched on the first beat of a word; later changes wait for IDLE.
    assign eff_mode  = (state_q == IDLE) ? mode : mode_q;
    assign count_inc = count_q + CW'(1);

    // Write-enable decode: slot `count` maps to a physical lane by MSB_FIRST.
    always_comb begin
        we = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (MSB_FIRST != 0) we[i] = (CW'(RATIO - 1 - i) == count_q);
            else                we[i] = (CW'(i) == count_q);
        end
    end

    // Slot contents as they would be with the current word written in.
    always_comb begin
        for (int i = 0; i < RATIO; i++)
            slots_wr[i] = we[i] ? in_data : slots_q[i];
    end

    // Next-state / completion logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        slots_d = slots_q;
        mode_d  = mode_q;
        done    = 1'b0;
        word    = slots_wr;
        cnt     = count_inc;
        if (eff_mode == MODE_REPL) begin
            word = {RATIO{in_data}};
            cnt  = CW'(RATIO);
        end
        if (acc_en) begin
            if (eff_mode == MODE_REPL || count_inc == CW'(RATIO) || in_last) begin
                done    = 1'b1;
                state_d = IDLE;
                count_d = '0;
                slots_d = '0;
            end else begin
                state_d = FILL;
                count_d = count_inc;
                slots_d = slots_wr;
                mode_d  = eff_mode;
            end
        end
    end

    // State register; reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            slots_q <= '0;
            mode_q  <= MODE_PACK;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            slots_q <= slots_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: rtl/word_packer.sv
// Packs RATIO narrow input words into one wide output word (or replicates a
// single word), with a valid/ready handshake on both sides and a registered
// output stage that sustains one beat per cycle.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int RATIO     = 4,
    parameter int MSB_FIRST = 1,
    localparam int CW       = clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_last,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RATIO*IN_W-1:0] out_data,
    output logic [CW-1:0]         out_cnt,
    output logic                  out_last
);

    logic                  acc_en;
    logic                  done;
    logic [RATIO*IN_W-1:0] word;
    logic [CW-1:0]         cnt;

    // Accept whenever the output register is empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign acc_en   = in_valid && in_ready;

    packer_accum #(
        .IN_W      (IN_W),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_en  (acc_en),
        .mode    (mode),
        .in_data (in_data),
        .in_last (in_last),
        .done    (done),
        .word    (word),
        .cnt     (cnt)
    );

    // Output register: load on completion (even while draining), else clear valid on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_cnt   <= cnt;
            out_last  <= in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: MSB-first main instance plus an LSB-first
// instance sharing the same stimulus.
module tb_word_packer;
    import word_packer_pkg::*;

    localparam int IN_W  = 4;
    localparam int RATIO = 4;
    localparam int CW    = clog2(RATIO + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic [IN_W-1:0]       in_data = '0;
    logic                  in_last = 1'b0;
    logic                  mode = 1'b0;
    logic                  out_ready = 1'b1;

    logic                  in_ready, out_valid, out_last;
    logic [RATIO*IN_W-1:0] out_data;
    logic [CW-1:0]         out_cnt;
    logic                  u1_in_ready, u1_out_valid, u1_out_last;
    logic [RATIO*IN_W-1:0] u1_out_data;
    logic [CW-1:0]         u1_out_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    word_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cnt(out_cnt), .out_last(out_last)
    );

    word_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u1_in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(u1_out_valid), .out_ready(out_ready), .out_data(u1_out_data),
        .out_cnt(u1_out_cnt), .out_last(u1_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle input beat, driven and returned on the falling edge.
    task automatic beat(input logic [IN_W-1:0] d, input logic l, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        mode     = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_cnt",   32'(out_cnt),   32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // full pack 1,2,3,4
        beat(4'h1, 1'b0, MODE_PACK);
        beat(4'h2, 1'b0, MODE_PACK);
        beat(4'h3, 1'b0, MODE_PACK);
        chk("pack_early_valid", 32'(out_valid), 32'd0);
        beat(4'h4, 1'b0, MODE_PACK);
        chk("pack_valid", 32'(out_valid), 32'd1);
        chk("pack_data",  32'(out_data),  32'h1234);
        chk("pack_cnt",   32'(out_cnt),   32'd4);
        chk("pack_last",  32'(out_last),  32'd0);
        chk("lsb_data",   32'(u1_out_data), 32'h4321);
        @(negedge clk);
        chk("pack_drained", 32'(out_valid), 32'd0);

        // partial word closed by in_last
        beat(4'h5, 1'b0, MODE_PACK);
        beat(4'h6, 1'b1, MODE_PACK);
        chk("part_valid", 32'(out_valid), 32'd1);
        chk("part_data",  32'(out_data),  32'h5600);
        chk("part_cnt",   32'(out_cnt),   32'd2);
        chk("part_last",  32'(out_last),  32'd1);
        chk("lsb_part",   32'(u1_out_data), 32'h0065);

        // replicate
        beat(4'hA, 1'b0, MODE_REPL);
        chk("repl_valid", 32'(out_valid), 32'd1);
        chk("repl_data",  32'(out_data),  32'hAAAA);
        chk("repl_cnt",   32'(out_cnt),   32'd4);
        @(negedge clk);

        // mode toggled mid-fill is ignored
        beat(4'h1, 1'b0, MODE_PACK);
        beat(4'h2, 1'b0, MODE_REPL);
        chk("tog_valid", 32'(out_valid), 32'd0);
        beat(4'h3, 1'b0, MODE_REPL);
        beat(4'h4, 1'b0, MODE_PACK);
        chk("tog_data", 32'(out_data), 32'h1234);
        chk("tog_cnt",  32'(out_cnt),  32'd4);
        @(negedge clk);

        // backpressure: hold 1234 while out_ready is low
        out_ready = 1'b0;
        beat(4'h1, 1'b0, MODE_PACK);
        beat(4'h2, 1'b0, MODE_PACK);
        beat(4'h3, 1'b0, MODE_PACK);
        beat(4'h4, 1'b0, MODE_PACK);
        chk("bp_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'h1234);
        end

        // release and stream 5,6,7,8 back to back
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            mode     = MODE_PACK;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("strm_valid", 32'(out_valid), 32'd1);
        chk("strm_data",  32'(out_data),  32'h5678);
        @(negedge clk);
        chk("strm_drain", 32'(out_valid), 32'd0);

        // replicate stream: consume and reload on the same edge, no bubble
        out_ready = 1'b0;
        beat(4'hB, 1'b0, MODE_REPL);
        chk("nb_hold", 32'(out_data), 32'hBBBB);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'hC;
        mode      = MODE_REPL;
        @(negedge clk);
        chk("nb_valid_c", 32'(out_valid), 32'd1);
        chk("nb_data_c",  32'(out_data),  32'hCCCC);
        in_data = 4'hD;
        in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("nb_valid_d", 32'(out_valid), 32'd1);
        chk("nb_data_d",  32'(out_data),  32'hDDDD);
        chk("nb_last_d",  32'(out_last),  32'd1);
        @(negedge clk);
        chk("nb_drop", 32'(out_valid), 32'd0);

        // reset mid-word discards the partial
        beat(4'h7, 1'b0, MODE_PACK);
        beat(4'h8, 1'b0, MODE_PACK);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        beat(4'h1, 1'b0, MODE_PACK);
        beat(4'h2, 1'b0, MODE_PACK);
        beat(4'h3, 1'b0, MODE_PACK);
        chk("rst_part_none", 32'(out_valid), 32'd0);
        beat(4'h4, 1'b0, MODE_PACK);
        chk("rst_after_data", 32'(out_data), 32'h1234);
        chk("rst_after_cnt",  32'(out_cnt),  32'd4);
        chk("rst_after_lsb",  32'(u1_out_data), 32'h4321);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 4, width of one input word.
REQ-002 SHALL have parameter RATIO, default 4, input words per output word (legal range 1..16).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 puts the first accepted word in the most-significant slot; 0 puts it in the least-significant slot.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input IN_W, in_last input 1 (last word of a packet).
REQ-007 SHALL have port mode, input, 1: 0 = pack, 1 = replicate.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_data output IN_W*RATIO, out_cnt output clog2(RATIO+1) (number of valid words), out_last output 1.

Function
REQ-009 An input beat SHALL be accepted when in_valid and in_ready are both high; an output beat SHALL be consumed when out_valid and out_ready are both high.
REQ-010 in_ready SHALL be high exactly when !out_valid || out_ready, combinationally.
REQ-011 The accumulator SHALL have two states: IDLE (count 0) and FILL (0 < count < RATIO).
REQ-012 The effective mode SHALL be sampled from mode only on a beat accepted in IDLE; mode changes during FILL SHALL be ignored until the block returns to IDLE.
REQ-013 Pack mode: each accepted word SHALL go into slot count (slot ordering per MSB_FIRST), and count SHALL increment.
REQ-014 Pack mode: a beat that brings count to RATIO, or that carries in_last, SHALL complete the output word.
REQ-015 On completion, out_data, out_cnt and out_last SHALL load on the same edge, and out_valid SHALL assert on that edge, one cycle after the completing beat.
REQ-016 On completion, the accumulator SHALL return to IDLE with all slots cleared.
REQ-017 On a partial word (completed by in_last early), unfilled slots SHALL be zero and out_cnt SHALL equal the number of words accepted.
REQ-018 Replicate mode: a single accepted word w SHALL complete immediately with out_data = {RATIO{w}}, out_cnt = RATIO and out_last = in_last.
REQ-019 With RATIO = 1, every accepted beat SHALL complete a word, in either mode.
REQ-020 A consume and a completing accept on the same edge SHALL reload the output; out_valid SHALL stay high with no bubble, giving a sustained rate of one beat per cycle.
REQ-021 While out_valid is high and out_ready is low, out_data, out_cnt and out_last SHALL hold stable.
REQ-022 out_valid SHALL deassert on a consume with no simultaneous completion.

Reset
REQ-023 While rst_n is low: out_valid = 0, out_data = 0, out_cnt = 0, out_last = 0, accumulator IDLE with slots zero, in_ready = 1.
REQ-024 Reset asserted mid-word SHALL discard the partial word; no output beat for it SHALL ever appear.
REQ-025 Reset SHALL assert asynchronously; release SHALL be synchronised to clk by the integrating level.

Structure
REQ-026 A shared package word_packer_pkg SHALL hold the constants MODE_PACK = 0 and MODE_REPL = 1 and the count-width function clog2.
REQ-027 The slot register and write-enable decode SHALL be one sub-module, packer_accum; the handshake and output register SHALL stay in word_packer.

Verification (IN_W=4, RATIO=4, MSB_FIRST=1 unless stated)
REQ-028 Pack 1,2,3,4, out_ready=1 -> out_data 16'h1234, out_cnt 4, out_last 0, one cycle after the 4th beat.
REQ-029 Pack 5,6 with in_last on 6 -> out_data 16'h5600, out_cnt 2, out_last 1.
REQ-030 mode=1, word 4'hA -> out_data 16'hAAAA, out_cnt 4; toggling mode mid-FILL in pack mode -> no effect.
REQ-031 out_ready=0, complete 16'h1234 -> in_ready 0, out_data stable for 5 cycles; out_ready=1 with 5,6,7,8 streaming -> 16'h5678 follows with no bubble.
REQ-032 Accept 7,8, pulse rst_n low, then accept 1,2,3,4 -> only 16'h1234 emitted; MSB_FIRST=0 with 1,2,3,4 -> 16'h4321.
